timer_core: RTL
===============

# timer_core

Programmable down-counting timer with prescaler, periodic and one-shot modes, a per-expiry pulse and a sticky interrupt flag. It sits directly downstream of the double-synchronized reset stage of the timer design. Its `rst` input is the inverted `dsyn_rst_n`, so every register in this block leaves reset on a clean clock edge.

## Interface
- `WIDTH`, 16: width of the count and reload value.
- `PSC_W`, 8: width of the prescale value.

- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `cfg_wr`  in  1  config write strobe; captures `cfg_reload`, `cfg_psc` and `cfg_oneshot`.
- `cfg_reload`  in  WIDTH  reload value.
- `cfg_psc`  in  PSC_W  prescale value; a tick occurs every `cfg_psc`+1 cycles.
- `cfg_oneshot`  in  1  1 = one-shot, 0 = periodic.
- `start`  in  1  start or restart the timer.
- `stop`  in  1  halt the timer; `count` is held.
- `irq_clr`  in  1  clear `irq_flag`.
- `count`  out  WIDTH  current count value.
- `running`  out  1  high in the RUN state.
- `expire`  out  1  one-cycle pulse when the count expires.
- `irq_flag`  out  1  sticky expiry flag.

## Operation
- Config registers `reload_r`, `psc_r` and `mode_r` load on `cfg_wr`, in any state.
- A write while in RUN takes effect only at the next start or the next periodic reload. The prescaler keeps the `psc_r` value latched at start (`psc_act`).
- States:
  - IDLE: reset state.
  - RUN: counting.
  - DONE: one-shot has expired.
- `start` (in any state):
  - `count` <= `reload_r`, prescaler counter <= 0, `psc_act` <= `psc_r`.
  - Next state is RUN.
- `stop` in RUN: next state is IDLE; `count` and the prescaler counter are frozen.
- `start` and `stop` asserted in the same cycle: `stop` wins.
- Prescaler in RUN:
  - `psc_cnt` increments each cycle.
  - When `psc_cnt` == `psc_act`, it generates `tick` and wraps to 0.
  - With `psc_act` = 0, `tick` occurs every cycle.
- On `tick` in RUN:
  - `count` != 0: `count` <= `count` - 1.
  - `count` == 0: expiry.
- Expiry:
  - `expire` = 1 for one cycle; `irq_flag` <= 1.
  - Periodic mode: `count` <= `reload_r`; stay in RUN.
  - One-shot mode: `count` stays 0; next state is DONE.
- Arithmetic is unsigned. `count` never wraps below 0.
- Period = (`reload`+1) × (`psc`+1) cycles. `reload` = 0 with `psc` = 0 expires every cycle.
- `irq_clr` clears `irq_flag`. If an expiry and `irq_clr` occur in the same cycle, the set wins.
- `cfg_wr` has no effect on `count`, `running` or the prescaler counter.

## Timing
- Reset values:
  - `count` = 0, `running` = 0, `expire` = 0, `irq_flag` = 0.
  - `reload_r` = 0, `psc_r` = 0, `mode_r` = 0; state = IDLE.
- `rst` overrides every other input. Asserting `rst` mid-count returns all of the above to their reset values on the next edge.
- All outputs are registered.
- `start` sampled at edge T gives `running` = 1 and `count` = `reload_r` after edge T.
- With `psc` = 0 and `reload` = R, `count` reaches 0 R cycles after start. `expire` is high in the following cycle, with `count` already reloaded (periodic mode).
- `stop` sampled at edge T gives `running` = 0 after T. No `expire` pulse is issued after the stop edge, even if a tick was due.
- `start` in RUN restarts immediately. No `expire` is issued for the aborted period.
- A restart from DONE behaves identically to a start from IDLE.

## Test plan
- Reset release: `rst` high for 3 cycles, then low.
  - All outputs 0 and state IDLE.
  - `start` with no prior config gives an `expire` pulse every cycle (reload 0, psc 0).
- Periodic, `reload` = 3, `psc` = 0, start at cycle 10:
  - `count` = 3, 2, 1, 0 over cycles 11–14.
  - `expire` pulses at 15, 19, 23.
  - `irq_flag` = 1 from cycle 15 onward.
- Prescaled one-shot, `reload` = 2, `psc` = 4:
  - Exactly one `expire`, 15 cycles after start.
  - `running` = 0 and `count` = 0 afterwards; the timer is in DONE.
- `stop` at `count` = 5:
  - `count` holds 5 and `running` = 0.
  - `start` + `stop` in the same cycle leaves it in IDLE.
  - A later `start` reloads and runs.
- `irq_clr` in the same cycle as an `expire` → `irq_flag` stays 1. `irq_clr` one cycle later → `irq_flag` = 0.
- `cfg_wr` (`reload` 3 → 7) mid-period:
  - The current period finishes with `reload` 3.
  - The next period counts from 7.
  - `rst` asserted mid-count returns all outputs to 0 on the next edge.

Source files
------------

// File: rtl/timer_core_if.sv
`default_nettype none
// ============================================================================
// Module   : timer_core_if
// Brief    : Configuration / control / status bundle for timer_core.
//            The master drives config and control; the slave (the timer)
//            returns count and status.
// Revision : 1.0  initial release
// ============================================================================
interface timer_core_if #(
    parameter int WIDTH = 16,
    parameter int PSC_W = 8
);
    logic             cfg_wr;
    logic [WIDTH-1:0] cfg_reload;
    logic [PSC_W-1:0] cfg_psc;
    logic             cfg_oneshot;
    logic             start;
    logic             stop;
    logic             irq_clr;
    logic [WIDTH-1:0] count;
    logic             running;
    logic             expire;
    logic             irq_flag;

    modport master (
        output cfg_wr, cfg_reload, cfg_psc, cfg_oneshot, start, stop, irq_clr,
        input  count, running, expire, irq_flag
    );

    modport slave (
        input  cfg_wr, cfg_reload, cfg_psc, cfg_oneshot, start, stop, irq_clr,
        output count, running, expire, irq_flag
    );
endinterface
`default_nettype wire

// File: rtl/timer_core.sv
`default_nettype none
// ============================================================================
// Module   : timer_core
// Brief    : Prescaled down-counting timer with periodic / one-shot modes,
//            a one-cycle expiry pulse and a sticky interrupt flag.
// Revision : 1.0  initial release
// ============================================================================
module timer_core #(
    parameter int WIDTH = 16,
    parameter int PSC_W = 8
) (
    input  wire logic   clk,
    input  wire logic   rst,
    timer_core_if.slave bus
);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_RUN  = 2'd1;
    localparam logic [1:0] c_ST_DONE = 2'd2;

    localparam logic [WIDTH-1:0] c_CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PSC_W-1:0] c_PSC_ONE = {{(PSC_W-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;

    logic [WIDTH-1:0] r_reload;
    logic [PSC_W-1:0] r_psc;
    logic             r_mode;

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_nxt;
    logic [PSC_W-1:0] r_psc_cnt;
    logic [PSC_W-1:0] w_psc_cnt_nxt;
    logic [PSC_W-1:0] r_psc_act;
    logic [PSC_W-1:0] w_psc_act_nxt;
    logic             r_running;
    logic             r_expire;
    logic             w_expire_nxt;
    logic             r_irq;
    logic             w_tick;

    // Prescaler terminal count; the prescale value in use is the one latched at start.
    assign w_tick = (r_state == c_ST_RUN) && (r_psc_cnt == r_psc_act);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and datapath next values. Stop beats start; start beats counting.
    always_comb begin
        w_state_nxt   = r_state;
        w_count_nxt   = r_count;
        w_psc_cnt_nxt = r_psc_cnt;
        w_psc_act_nxt = r_psc_act;
        w_expire_nxt  = 1'b0;
        if (bus.stop) begin
            if (r_state == c_ST_RUN) begin
                w_state_nxt = c_ST_IDLE;
            end
        end else if (bus.start) begin
            w_state_nxt   = c_ST_RUN;
            w_count_nxt   = r_reload;
            w_psc_cnt_nxt = '0;
            w_psc_act_nxt = r_psc;
        end else if (r_state == c_ST_RUN) begin
            if (w_tick) begin
                w_psc_cnt_nxt = '0;
                if (r_count != '0) begin
                    w_count_nxt = r_count - c_CNT_ONE;
                end else begin
                    w_expire_nxt = 1'b1;
                    if (r_mode) begin
                        w_state_nxt = c_ST_DONE;
                    end else begin
                        w_count_nxt = r_reload;
                    end
                end
            end else begin
                w_psc_cnt_nxt = r_psc_cnt + c_PSC_ONE;
            end
        end
    end

    // Config registers; a write during RUN is only seen at the next start or reload.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_reload <= '0;
            r_psc    <= '0;
            r_mode   <= 1'b0;
        end else if (bus.cfg_wr) begin
            r_reload <= bus.cfg_reload;
            r_psc    <= bus.cfg_psc;
            r_mode   <= bus.cfg_oneshot;
        end
    end

    // Counter, prescaler and registered status outputs; a new expiry outranks irq_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_psc_cnt <= '0;
            r_psc_act <= '0;
            r_running <= 1'b0;
            r_expire  <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_count   <= w_count_nxt;
            r_psc_cnt <= w_psc_cnt_nxt;
            r_psc_act <= w_psc_act_nxt;
            r_running <= (w_state_nxt == c_ST_RUN);
            r_expire  <= w_expire_nxt;
            r_irq     <= w_expire_nxt | (r_irq & ~bus.irq_clr);
        end
    end

    assign bus.count    = r_count;
    assign bus.running  = r_running;
    assign bus.expire   = r_expire;
    assign bus.irq_flag = r_irq;

endmodule
`default_nettype wire
